tetris_move_scheduler: RTL and testbench

// - Arbitrates all piece-motion requests into one serialized command stream for the tetris game FSM.
// - Request sources: player buttons (left, right, rotate, hard drop) and the 1 Hz gravity tick.
// - Sits between the pb[] inputs / clkdiv1hz and tetrisFSM, in the hz100 domain.
// - Guarantees at most one grid move in flight; rejects conflicting inputs; flags dropped gravity ticks.

---
 rtl/tetris_move_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_tetris_move_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_move_scheduler.sv
// Serializes button and gravity motion requests into one command stream for the game FSM.
// Optional macro AUTO_REPEAT_EN adds held-button auto-repeat for left/right.
module tetris_move_scheduler #(
  parameter int SYNC_STAGES  = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int ACK_TIMEOUT  = 8,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       onehuzz,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       rotate_i,
  input  logic       drop_i,
  input  logic       freeze,
  input  logic       move_ack,
  output logic       move_req,
  output logic [2:0] move_cmd,
  output logic [4:0] pending,
  output logic       grav_overrun,
  output logic       ack_timeout
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t                        state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]   btn_sync_q, btn_sync_d;
  logic [3:0]                    btn_prev_q, btn_prev_d;
  logic [1:0]                    grav_sync_q, grav_sync_d;
  logic                          grav_prev_q, grav_prev_d;
  logic [4:0]                    rise_q, rise_d;
  logic [4:0]                    pending_q, pending_d;
  logic                          move_req_q, move_req_d;
  logic [2:0]                    move_cmd_q, move_cmd_d;
  logic                          grav_overrun_q, grav_overrun_d;
  logic                          ack_timeout_q, ack_timeout_d;
  logic [AW-1:0]                 timer_q, timer_d;
  logic [GW-1:0]                 gap_q, gap_d;
  logic [3:0]                    btn_lvl;
  logic [1:0]                    rep_fire;
  logic [4:0]                    set_v, clr_v, cur_bit;

  assign btn_lvl = btn_sync_q[SYNC_STAGES-1];

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_TICKS) ? REPEAT_DELAY : REPEAT_TICKS;
  localparam int RW = $clog2(REP_MAX + 1);
  logic [1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0]         rep_armed_q, rep_armed_d;

  // Index 0 is left, 1 is right; holding both suppresses repeat and restarts the count.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 2'b00;
    for (int d = 0; d < 2; d++) begin
      if (!btn_lvl[d] || btn_lvl[1-d]) begin
        rep_cnt_d[d]   = '0;
        rep_armed_d[d] = 1'b0;
      end else if (rep_cnt_q[d] == (rep_armed_q[d] ? RW'(REPEAT_TICKS) : RW'(REPEAT_DELAY))) begin
        rep_fire[d]    = 1'b1;
        rep_cnt_d[d]   = RW'(1);
        rep_armed_d[d] = 1'b1;
      end else begin
        rep_cnt_d[d] = rep_cnt_q[d] + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= '0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  assign rep_fire = 2'b00;
`endif

  always_comb begin
    case (move_cmd_q)
      3'd1:    cur_bit = 5'b00001;
      3'd2:    cur_bit = 5'b00010;
      3'd3:    cur_bit = 5'b00100;
      3'd4:    cur_bit = 5'b01000;
      3'd5:    cur_bit = 5'b11000; // a landed drop also retires any pending gravity step
      default: cur_bit = 5'b00000;
    endcase
  end

  always_comb begin
    btn_sync_d     = {btn_sync_q[SYNC_STAGES-2:0], {drop_i, rotate_i, right_i, left_i}};
    grav_sync_d    = {grav_sync_q[0], onehuzz};
    btn_prev_d     = btn_lvl;
    grav_prev_d    = grav_sync_q[1];
    rise_d         = {btn_lvl[3] & ~btn_prev_q[3],
                      grav_sync_q[1] & ~grav_prev_q,
                      btn_lvl[2] & ~btn_prev_q[2],
                      (btn_lvl[1] & ~btn_prev_q[1]) | rep_fire[1],
                      (btn_lvl[0] & ~btn_prev_q[0]) | rep_fire[0]};
    state_d        = state_q;
    move_req_d     = move_req_q;
    move_cmd_d     = move_cmd_q;
    timer_d        = timer_q;
    gap_d          = gap_q;
    ack_timeout_d  = 1'b0;
    clr_v          = 5'b00000;
    set_v          = rise_q;
    if (rise_q[0] && rise_q[1]) set_v[1:0] = 2'b00;

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          if (pending_q[4])      move_cmd_d = 3'd5;
          else if (pending_q[3]) move_cmd_d = 3'd4;
          else if (pending_q[2]) move_cmd_d = 3'd3;
          else if (pending_q[0]) move_cmd_d = 3'd1;
          else                   move_cmd_d = 3'd2;
          move_req_d = 1'b1;
          timer_d    = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (move_ack || timer_q == ACK_LAST) begin
          clr_v         = move_ack ? cur_bit : (cur_bit & 5'b00111) | (move_cmd_q == 3'd4 ? 5'b01000 : 5'b00000) | (move_cmd_q == 3'd5 ? 5'b10000 : 5'b00000);
          ack_timeout_d = ~move_ack;
          move_req_d    = 1'b0;
          move_cmd_d    = 3'd0;
          gap_d         = '0;
          state_d       = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          timer_d = timer_q + AW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    pending_d      = (pending_q & ~clr_v) | set_v;
    grav_overrun_d = grav_overrun_q | (rise_q[3] & pending_q[3]);

    if (freeze) begin
      pending_d      = '0;
      grav_overrun_d = 1'b0;
      state_d        = IDLE;
      move_req_d     = 1'b0;
      move_cmd_d     = 3'd0;
      timer_d        = '0;
      gap_d          = '0;
      ack_timeout_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      btn_sync_q     <= '0;
      btn_prev_q     <= '0;
      grav_sync_q    <= '0;
      grav_prev_q    <= 1'b0;
      rise_q         <= '0;
      pending_q      <= '0;
      move_req_q     <= 1'b0;
      move_cmd_q     <= 3'd0;
      grav_overrun_q <= 1'b0;
      ack_timeout_q  <= 1'b0;
      timer_q        <= '0;
      gap_q          <= '0;
    end else begin
      state_q        <= state_d;
      btn_sync_q     <= btn_sync_d;
      btn_prev_q     <= btn_prev_d;
      grav_sync_q    <= grav_sync_d;
      grav_prev_q    <= grav_prev_d;
      rise_q         <= rise_d;
      pending_q      <= pending_d;
      move_req_q     <= move_req_d;
      move_cmd_q     <= move_cmd_d;
      grav_overrun_q <= grav_overrun_d;
      ack_timeout_q  <= ack_timeout_d;
      timer_q        <= timer_d;
      gap_q          <= gap_d;
    end
  end

  assign move_req     = move_req_q;
  assign move_cmd     = move_cmd_q;
  assign pending      = pending_q;
  assign grav_overrun = grav_overrun_q;
  assign ack_timeout  = ack_timeout_q;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed bench for tetris_move_scheduler: vector table plus multi-cycle corner sequences.
module tb_tetris_move_scheduler;

  localparam int SYNC_STAGES = 2;
  localparam int GAP_CYCLES  = 1;
  localparam int ACK_TIMEOUT = 8;
  localparam int REQ_LAT     = SYNC_STAGES + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       onehuzz, left_i, right_i, rotate_i, drop_i, freeze, move_ack;
  logic       move_req;
  logic [2:0] move_cmd;
  logic [4:0] pending;
  logic       grav_overrun, ack_timeout;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  tetris_move_scheduler #(
    .SYNC_STAGES(SYNC_STAGES), .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT),
    .REPEAT_DELAY(30), .REPEAT_TICKS(10)
  ) dut (
    .clk(clk), .reset(reset), .onehuzz(onehuzz), .left_i(left_i), .right_i(right_i),
    .rotate_i(rotate_i), .drop_i(drop_i), .freeze(freeze), .move_ack(move_ack),
    .move_req(move_req), .move_cmd(move_cmd), .pending(pending),
    .grav_overrun(grav_overrun), .ack_timeout(ack_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] press;     // {drop, gravity, rotate, right, left}
    logic [4:0] exp_pend;
    logic [2:0] exp_cmd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_press(input logic [4:0] p);
    left_i   = p[0];
    right_i  = p[1];
    rotate_i = p[2];
    onehuzz  = p[3];
    drop_i   = p[4];
  endtask

  initial begin
    int n, hi, issues, lows, sep, seen;
    logic [7:0] exp_v;

    vecs[0]  = '{5'b00001, 5'b00001, 3'd1};
    vecs[1]  = '{5'b00010, 5'b00010, 3'd2};
    vecs[2]  = '{5'b00100, 5'b00100, 3'd3};
    vecs[3]  = '{5'b01000, 5'b01000, 3'd4};
    vecs[4]  = '{5'b10000, 5'b10000, 3'd5};
    vecs[5]  = '{5'b00011, 5'b00000, 3'd0};
    vecs[6]  = '{5'b00101, 5'b00101, 3'd3};
    vecs[7]  = '{5'b00111, 5'b00100, 3'd3};
    vecs[8]  = '{5'b11100, 5'b11100, 3'd5};
    vecs[9]  = '{5'b01010, 5'b01010, 3'd4};
    vecs[10] = '{5'b11111, 5'b11100, 3'd5};
    vecs[11] = '{5'b01001, 5'b01001, 3'd4};

    reset = 1'b1;
    apply_press(5'b00000);
    freeze   = 1'b0;
    move_ack = 1'b0;
    cyc(3);
    check("rst_move_req", move_req, 0);
    check("rst_move_cmd", move_cmd, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", grav_overrun, 0);
    check("rst_ack_timeout", ack_timeout, 0);
    reset = 1'b0;
    cyc(3);

    for (int v = 0; v < 12; v++) begin
      move_ack = 1'b0;
      apply_press(vecs[v].press);
      cyc(REQ_LAT - 1);
      check($sformatf("vec%0d_pending", v), pending, vecs[v].exp_pend);
      check($sformatf("vec%0d_req_early", v), move_req, 0);
      cyc(1);
      check($sformatf("vec%0d_req", v), move_req, (vecs[v].exp_cmd != 0));
      check($sformatf("vec%0d_cmd", v), move_cmd, vecs[v].exp_cmd);
      move_ack = 1'b1;
      apply_press(5'b00000);
      cyc(30);
      check($sformatf("vec%0d_drained", v), {move_req, pending}, 0);
    end

    // Left press with ack already high: issue, one gap cycle, pending clear.
    move_ack = 1'b1;
    left_i   = 1'b1;
    cyc(REQ_LAT - 1);
    check("left_req_before", move_req, 0);
    cyc(1);
    check("left_req", move_req, 1);
    check("left_cmd", move_cmd, 1);
    cyc(1);
    check("left_gap_req", move_req, 0);
    check("left_gap_pending", pending, 0);
    left_i = 1'b0;
    cyc(10);

    // Drop, gravity and rotate together: drop retires the gravity step.
    exp_q.push_back(8'd5);
    exp_q.push_back(8'd3);
    apply_press(5'b11100);
    issues = 0; lows = 0; sep = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (move_req) begin
        if (exp_q.size() == 0) begin
          check("seq_extra_cmd", move_cmd, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("seq_cmd", {5'd0, move_cmd}, exp_v);
        end
        if (issues == 1) sep = lows;
        issues++;
        lows = 0;
      end else if (issues > 0) begin
        lows++;
      end
    end
    check("seq_all_issued", exp_q.size(), 0);
    check("seq_issue_count", issues, 2);
    check("seq_separation", sep, GAP_CYCLES + 1);
    apply_press(5'b00000);
    cyc(10);

    // Two gravity edges with no ack: overrun, then the step is abandoned.
    move_ack = 1'b0;
    onehuzz  = 1'b1;
    cyc(2);
    onehuzz = 1'b0;
    cyc(2);
    onehuzz = 1'b1;
    n = 0;
    while (!move_req && n < 20) begin
      cyc(1);
      n++;
    end
    hi = 0;
    while (move_req && hi < 20) begin
      hi++;
      cyc(1);
    end
    check("to_req_cycles", hi, ACK_TIMEOUT);
    check("to_pulse", ack_timeout, 1);
    check("to_overrun", grav_overrun, 1);
    check("to_pending", pending, 0);
    cyc(1);
    check("to_pulse_end", ack_timeout, 0);
    onehuzz = 1'b0;
    cyc(6);
    check("overrun_sticky", grav_overrun, 1);

    // Freeze during issue, then a press while frozen.
    rotate_i = 1'b1;
    n = 0;
    while (!move_req && n < 20) begin
      cyc(1);
      n++;
    end
    check("frz_req_before", move_req, 1);
    freeze = 1'b1;
    cyc(1);
    check("frz_req", move_req, 0);
    check("frz_cmd", move_cmd, 0);
    check("frz_pending", pending, 0);
    check("frz_overrun", grav_overrun, 0);
    left_i = 1'b1;
    cyc(8);
    freeze = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (move_req) seen++;
    end
    check("frz_no_req", seen, 0);
    check("frz_pending_after", pending, 0);
    apply_press(5'b00000);
    cyc(8);

    // Asynchronous reset while a command is being offered.
    drop_i = 1'b1;
    n = 0;
    while (!move_req && n < 20) begin
      cyc(1);
      n++;
    end
    check("rst_mid_req_before", move_req, 1);
    #2;
    reset  = 1'b1;
    drop_i = 1'b0;
    #1;
    check("rst_mid_req", move_req, 0);
    check("rst_mid_pending", pending, 0);
    cyc(1);
    reset = 1'b0;
    cyc(10);
    check("rst_mid_after", {move_req, pending}, 0);

`ifdef AUTO_REPEAT_EN
    // Right held for 60 cycles with immediate ack: edge, then +30, +40, +50.
    exp_q.push_back(8'(REQ_LAT));
    exp_q.push_back(8'(REQ_LAT + 30));
    exp_q.push_back(8'(REQ_LAT + 40));
    exp_q.push_back(8'(REQ_LAT + 50));
    move_ack = 1'b1;
    right_i  = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      cyc(1);
      if (i == 60) right_i = 1'b0;
      if (move_req) begin
        if (exp_q.size() == 0) begin
          check("rep_extra", i, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("rep_time", i, exp_v);
          check("rep_cmd", move_cmd, 2);
        end
      end
    end
    check("rep_all_issued", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
